// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Operation encoding matches the funct3 low bits of DIV/DIVU/REM/REMU.
package div_pkg;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    function automatic logic op_is_signed(div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-and-subtract iteration of the divider.
// Combinational; the top reuses a single instance on every CALC cycle.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    // The shifted remainder keeps its top bit in bit WIDTH, so a divisor above
    // 2^(WIDTH-1) still compares correctly; bit WIDTH of the difference is the borrow.
    assign partial  = {rem, dvd_msb};
    assign diff     = partial - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/divider_32bit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with a start/valid handshake.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module divider_32bit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] re_o
);

    div_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    div_op_e          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             q_neg, r_neg, div_zero, ovf;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic             accept, last_step;
    logic             in_signed, a_neg, b_neg, b_zero, in_ovf;
    logic [WIDTH-1:0] q_fix, r_fix, result;

    assign in_signed = op_is_signed(div_op_e'(op_i));
    assign a_neg     = in_signed & a_i[WIDTH-1];
    assign b_neg     = in_signed & b_i[WIDTH-1];
    assign b_zero    = (b_i == '0);
    assign in_ovf    = in_signed && (a_i == INT_MIN) && (b_i == '1);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // The valid_o cycle still belongs to the result hand-off, so a start
    // presented alongside the pulse is not taken until the following cycle.
    assign ready_o = (state == IDLE) && !valid_o;
    assign busy_o  = !ready_o;
    assign accept  = start_i && ready_o;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: defaults first in every combinational block so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (b_zero || in_ovf) ? DONE : CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        q_fix = q_neg ? -dvd : dvd;
        r_fix = r_neg ? -rem : rem;
        if (div_zero)      result = op_is_rem(op_q) ? a_q : DIV_ZERO_Q;
        else if (ovf)      result = op_is_rem(op_q) ? '0  : INT_MIN;
        else               result = op_is_rem(op_q) ? r_fix : q_fix;
    end

    // dvd shifts the dividend out of its top while quotient bits enter at the bottom.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt      <= '0;
            op_q     <= DIV;
            a_q      <= '0;
            dvd      <= '0;
            rem      <= '0;
            divisor  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            valid_o  <= 1'b0;
            re_o     <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_q     <= div_op_e'(op_i);
                    a_q      <= a_i;
                    dvd      <= a_neg ? -a_i : a_i;
                    divisor  <= b_neg ? -b_i : b_i;
                    rem      <= '0;
                    cnt      <= '0;
                    q_neg    <= a_neg ^ b_neg;
                    r_neg    <= a_neg;
                    div_zero <= b_zero;
                    ovf      <= in_ovf;
                end
                CALC: begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                end
                DONE: begin
                    re_o    <= result;
                    valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
